reflet_interrupt_ctrl: RTL and testbench
========================================

// Module: reflet_interrupt_ctrl
// PURPOSE
//  Parametrised nested interrupt controller for the reflet CPU. Accepts INT_COUNT
//  prioritised sources, each level- or edge-sensitive. Keeps a DEPTH-deep
//  hardware stack of {return PC, previous level} so handlers can nest.
//  Decodes setint/retint from the CPU instruction stream.
//  Replaces the fixed 4-source, level-only controller and adds overflow reporting.
// PARAMETERS
//  wordsize   16    CPU word width; width of PC, routine addresses and out.
//  INT_COUNT  4     number of sources, 1..4; index 0 has the highest priority.
//  DEPTH      4     nesting stack entries, >=1.
//  EDGE_MODE  4'b0  bit i=1: source i is rising-edge latched; bit i=0: level.
// PORTS
//  clk               in   1          system clock, rising edge.
//  reset             in   1          asynchronous, active-low reset.
//  enable            in   1          CPU enable; level/stack/pending frozen when 0.
//  ext_int           in   INT_COUNT  raw interrupt requests, already synchronous to clk.
//  instruction       in   8          current CPU instruction byte.
//  working_register  in   wordsize   CPU working register (setint operand).
//  program_counter   in   wordsize   PC pushed on interrupt entry.
//  int_mask          in   INT_COUNT  1 = source enabled.
//  cpu_update        in   1          CPU commits a new instruction this cycle.
//  out               out  wordsize   data to CPU register file.
//  out_reg           out  4          destination register id (0 = none).
//  out_routine       out  wordsize   handler address of target source.
//  int               out  1          take interrupt now (1-cycle strobe).
//  nest_level        out  3          current level; INT_COUNT = normal context.
//  overflow          out  1          sticky: interrupt refused because stack full.
// BEHAVIOUR
//  Reset (async, reset=0): level=INT_COUNT, stack pointer=0, all routines=0,
//   pending=0, edge history=0, overflow=0.
//   Combinational outputs then follow inputs; int=0 because cpu_update is gated.
//  Request vector req[i]:
//   - Level source: ext_int[i].
//   - Edge source: pending[i]. pending sets on ext_int rising (registered history).
//     It clears on the edge where source i is taken. Set and clear on the same
//     edge: set wins.
//   - Edge latching runs even when enable=0.
//  target = lowest i with req[i]&int_mask[i]; INT_COUNT if none.
//  Entry and return conditions:
//   - full  = (sp==DEPTH); empty = (sp==0).
//   - new_int = enable & cpu_update & (target<level) & !full.
//   - quit_int = enable & cpu_update & !new_int & (instruction==`inst_retint) & !empty.
//  Outputs:
//   - int = new_int, combinational, same cycle; out_routine = routines[target],
//     0 when target==INT_COUNT.
//  On new_int edge: push {program_counter, level}, sp+1, level<=target.
//  On quit_int edge: pop, sp-1, level<=popped level.
//  Preemption: only strictly higher priority (lower index) preempts; equal/lower waits.
//  Stack full:
//   - A would-be interrupt is refused and overflow<=1 (sticky until reset).
//   - The request stays pending and is taken after a retint frees an entry.
//  Instruction decode (combinational):
//   - setint (instruction[7:2]==`opp_setint): out=working_register, out_reg=0.
//     routines[instruction[1:0]]<=working_register on clk, regardless of enable.
//     An index >= INT_COUNT is ignored.
//   - retint, stack non-empty: out=top-of-stack PC, out_reg=`pc_id.
//   - retint, stack empty: out=0, out_reg=0, no state change.
//   - Otherwise: out=0, out_reg=0.
//  new_int and retint in the same cycle: interrupt wins, no pop.
//   The retint re-executes after the handler.
// TESTING
//  - Reset: ext_int=0, reset pulsed low mid-clock -> immediate nest_level=4,
//    int=0, overflow=0, routines read 0.
//  - setint idx1 with WR=16'h0120, then level ext_int[1]=1, mask=4'hF,
//    cpu_update=1, PC=16'h0040 -> int=1, out_routine=16'h0120; next edge
//    nest_level=1. retint -> out=16'h0040, out_reg=`pc_id, nest_level=4.
//  - In level 2, ext_int[3] -> no int. ext_int[0] -> int, nest_level 2->0.
//    Two retints restore 2 then 4.
//  - EDGE_MODE=4'b0100, 1-cycle pulse on ext_int[2] while enable=0 -> pending held.
//    enable=1, cpu_update=1 -> int=1 once. No second int after retint.
//  - DEPTH=2, nest sources 3,2 then assert 1 -> int stays 0, overflow=1.
//    retint -> source 1 taken on the next cpu_update.
//  - retint with empty stack -> out=0, out_reg=0, nest_level unchanged.

Source files
------------

// File: rtl/reflet_interrupt_ctrl.sv
// rtl/reflet_interrupt_ctrl.sv - nested, prioritised interrupt controller for the reflet CPU
// Level/edge sources, DEPTH-deep {PC, level} stack, setint/retint decode, sticky overflow.
module reflet_interrupt_ctrl #(
    parameter int              wordsize    = 16,
    parameter int              INT_COUNT   = 4,
    parameter int              DEPTH       = 4,
    parameter logic [3:0]      EDGE_MODE   = 4'b0000,
    parameter logic [5:0]      OPP_SETINT  = 6'b000001,
    parameter logic [7:0]      INST_RETINT = 8'h0A,
    parameter logic [3:0]      PC_ID       = 4'hE
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [INT_COUNT-1:0] ext_int_i,
    input  logic [7:0]           instruction_i,
    input  logic [wordsize-1:0]  working_register_i,
    input  logic [wordsize-1:0]  program_counter_i,
    input  logic [INT_COUNT-1:0] int_mask_i,
    input  logic                 cpu_update_i,
    output logic [wordsize-1:0]  out_o,
    output logic [3:0]           out_reg_o,
    output logic [wordsize-1:0]  out_routine_o,
    output logic                 int_o,
    output logic [2:0]           nest_level_o,
    output logic                 overflow_o
);

    localparam int                   SPW      = $clog2(DEPTH + 1);
    localparam logic [2:0]           IDLE_LVL = 3'(INT_COUNT);
    localparam logic [INT_COUNT-1:0] EDGE_SRC = EDGE_MODE[INT_COUNT-1:0];

    logic [2:0]           level_q, level_d;
    logic [SPW-1:0]       sp_q, sp_d;
    logic [INT_COUNT-1:0] pending_q, pending_d;
    logic [INT_COUNT-1:0] hist_q;
    logic                 overflow_q, overflow_d;
    logic [wordsize-1:0]  routine_q [INT_COUNT];
    logic [wordsize-1:0]  stk_pc_q  [DEPTH];
    logic [2:0]           stk_lvl_q [DEPTH];

    logic [INT_COUNT-1:0] req;
    logic [INT_COUNT-1:0] take;
    logic [2:0]           target;
    logic                 full, empty, want_int, new_int, quit_int;
    logic                 is_setint, is_retint;
    logic [wordsize-1:0]  top_pc;
    logic [2:0]           top_lvl;

    // Edge sources are served from the latched pending bit, level sources straight from the pin.
    assign req = (EDGE_SRC & pending_q) | (~EDGE_SRC & ext_int_i);

    always_comb begin
        target = IDLE_LVL;
        for (int i = INT_COUNT - 1; i >= 0; i--) begin
            if (req[i] && int_mask_i[i]) begin
                target = 3'(i);
            end
        end
    end

    assign full      = (sp_q == SPW'(DEPTH));
    assign empty     = (sp_q == '0);
    assign is_setint = (instruction_i[7:2] == OPP_SETINT);
    assign is_retint = (instruction_i == INST_RETINT);
    assign want_int  = enable_i && cpu_update_i && (target < level_q);
    assign new_int   = want_int && !full;
    // An interrupt beats a retint in the same cycle; the retint re-executes after the handler.
    assign quit_int  = enable_i && cpu_update_i && !new_int && is_retint && !empty;

    always_comb begin
        top_pc  = '0;
        top_lvl = IDLE_LVL;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == SPW'(i + 1)) begin
                top_pc  = stk_pc_q[i];
                top_lvl = stk_lvl_q[i];
            end
        end
    end

    always_comb begin
        out_routine_o = '0;
        for (int i = 0; i < INT_COUNT; i++) begin
            if (target == 3'(i)) begin
                out_routine_o = routine_q[i];
            end
        end
    end

    always_comb begin
        out_o     = '0;
        out_reg_o = 4'd0;
        if (is_setint) begin
            out_o = working_register_i;
        end else if (is_retint && !empty) begin
            out_o     = top_pc;
            out_reg_o = PC_ID;
        end
    end

    always_comb begin
        take = '0;
        for (int i = 0; i < INT_COUNT; i++) begin
            if (new_int && (target == 3'(i))) begin
                take[i] = 1'b1;
            end
        end
    end

    always_comb begin
        level_d    = level_q;
        sp_d       = sp_q;
        overflow_d = overflow_q | (want_int && full);
        // A new rising edge outranks the clear of the same source.
        pending_d  = (pending_q & ~take) | (EDGE_SRC & ext_int_i & ~hist_q);
        if (new_int) begin
            sp_d    = sp_q + 1'b1;
            level_d = target;
        end else if (quit_int) begin
            sp_d    = sp_q - 1'b1;
            level_d = top_lvl;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            level_q    <= IDLE_LVL;
            sp_q       <= '0;
            pending_q  <= '0;
            hist_q     <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < INT_COUNT; i++) begin
                routine_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                stk_pc_q[i]  <= '0;
                stk_lvl_q[i] <= IDLE_LVL;
            end
        end else begin
            level_q    <= level_d;
            sp_q       <= sp_d;
            pending_q  <= pending_d;
            hist_q     <= ext_int_i;
            overflow_q <= overflow_d;
            if (is_setint) begin
                for (int i = 0; i < INT_COUNT; i++) begin
                    if (instruction_i[1:0] == 2'(i)) begin
                        routine_q[i] <= working_register_i;
                    end
                end
            end
            if (new_int) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (sp_q == SPW'(i)) begin
                        stk_pc_q[i]  <= program_counter_i;
                        stk_lvl_q[i] <= level_q;
                    end
                end
            end
        end
    end

    assign int_o        = new_int;
    assign nest_level_o = level_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_reflet_interrupt_ctrl.sv
// tb/tb_reflet_interrupt_ctrl.sv - scoreboard bench for reflet_interrupt_ctrl
// Stimulus queues expected interrupt entries; a negedge monitor pops them on every int strobe.
module tb_reflet_interrupt_ctrl;

    localparam logic [7:0] RETINT = 8'h0A;
    localparam logic [7:0] NOP    = 8'h00;
    localparam logic [3:0] PCID   = 4'hE;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  ext_int;
    logic [7:0]  instruction;
    logic [15:0] wr;
    logic [15:0] pc;
    logic [3:0]  mask;
    logic        cpu_update;
    logic [15:0] out;
    logic [3:0]  out_reg;
    logic [15:0] out_routine;
    logic        int_s;
    logic [2:0]  nest_level;
    logic        overflow;

    typedef struct {
        logic [15:0] routine;
        logic [2:0]  lvl;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    reflet_interrupt_ctrl #(
        .wordsize    (16),
        .INT_COUNT   (4),
        .DEPTH       (2),
        .EDGE_MODE   (4'b0100),
        .OPP_SETINT  (6'b000001),
        .INST_RETINT (RETINT),
        .PC_ID       (PCID)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .enable_i           (enable),
        .ext_int_i          (ext_int),
        .instruction_i      (instruction),
        .working_register_i (wr),
        .program_counter_i  (pc),
        .int_mask_i         (mask),
        .cpu_update_i       (cpu_update),
        .out_o              (out),
        .out_reg_o          (out_reg),
        .out_routine_o      (out_routine),
        .int_o              (int_s),
        .nest_level_o       (nest_level),
        .overflow_o         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_int(input logic [15:0] routine, input logic [2:0] lvl);
        exp_t e;
        e.routine = routine;
        e.lvl     = lvl;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (int_s === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_int: got routine %h level %0d expected no interrupt", out_routine, nest_level);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("int_routine", {16'd0, out_routine}, {16'd0, e.routine});
                chk("int_level", {29'd0, nest_level}, {29'd0, e.lvl});
            end
        end
    end

    logic [15:0] rvals [4];

    initial begin
        rvals[0] = 16'h0300; rvals[1] = 16'h0120; rvals[2] = 16'h0200; rvals[3] = 16'h0400;
        reset = 1'b1; enable = 1'b1; ext_int = 4'b0001; mask = 4'hF;
        instruction = NOP; wr = '0; pc = '0; cpu_update = 1'b0;

        // Reset asserted mid-cycle takes effect immediately.
        #7 reset = 1'b0;
        #1;
        chk("rst_level", {29'd0, nest_level}, 32'd4);
        chk("rst_int", {31'd0, int_s}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_routine0", {16'd0, out_routine}, 32'd0);
        cyc();
        reset = 1'b1;
        ext_int = 4'b0000;

        // Program all four routines; index 3 with enable low.
        for (int i = 0; i < 4; i++) begin
            enable = (i != 3);
            instruction = 8'h04 | 8'(i);
            wr = rvals[i];
            #2;
            chk("setint_out", {16'd0, out}, {16'd0, rvals[i]});
            chk("setint_reg", {28'd0, out_reg}, 32'd0);
            cyc();
        end
        enable = 1'b1; instruction = NOP;

        // Level source 1 enters and returns.
        ext_int = 4'b0010; cpu_update = 1'b1; pc = 16'h0040;
        expect_int(16'h0120, 3'd4);
        #2;
        chk("l1_int", {31'd0, int_s}, 32'd1);
        chk("l1_routine", {16'd0, out_routine}, 32'h0120);
        cyc();
        chk("l1_level", {29'd0, nest_level}, 32'd1);
        ext_int = 4'b0000; instruction = RETINT;
        #2;
        chk("l1_ret_out", {16'd0, out}, 32'h0040);
        chk("l1_ret_reg", {28'd0, out_reg}, {28'd0, PCID});
        cyc();
        chk("l1_ret_level", {29'd0, nest_level}, 32'd4);

        // Edge source 2 pulsed while disabled: latched, taken once when enabled.
        instruction = NOP; enable = 1'b0; ext_int = 4'b0100; pc = 16'h0050;
        #2;
        chk("edge_dis_int", {31'd0, int_s}, 32'd0);
        cyc();
        ext_int = 4'b0000;
        cyc();
        chk("edge_hold_level", {29'd0, nest_level}, 32'd4);
        enable = 1'b1;
        expect_int(16'h0200, 3'd4);
        #2;
        chk("edge_int", {31'd0, int_s}, 32'd1);
        cyc();
        chk("edge_level", {29'd0, nest_level}, 32'd2);
        #2;
        chk("edge_once", {31'd0, int_s}, 32'd0);

        // Lower priority waits, higher priority preempts.
        ext_int = 4'b1000;
        #2;
        chk("lower_no_int", {31'd0, int_s}, 32'd0);
        cyc();
        ext_int = 4'b1001; pc = 16'h0060;
        expect_int(16'h0300, 3'd2);
        #2;
        chk("preempt_int", {31'd0, int_s}, 32'd1);
        cyc();
        chk("preempt_level", {29'd0, nest_level}, 32'd0);
        ext_int = 4'b0000; instruction = RETINT;
        #2;
        chk("ret0_out", {16'd0, out}, 32'h0060);
        cyc();
        chk("ret0_level", {29'd0, nest_level}, 32'd2);
        #2;
        chk("ret2_out", {16'd0, out}, 32'h0050);
        cyc();
        chk("ret2_level", {29'd0, nest_level}, 32'd4);
        instruction = NOP;
        #2;
        chk("edge_no_repeat", {31'd0, int_s}, 32'd0);
        cyc();

        // Fill the two-entry stack with 3 then 2, then request 1.
        ext_int = 4'b1000; pc = 16'h0070;
        expect_int(16'h0400, 3'd4);
        cyc();
        chk("ovf_l3", {29'd0, nest_level}, 32'd3);
        ext_int = 4'b1100; pc = 16'h0080;
        cyc();
        ext_int = 4'b1000;
        expect_int(16'h0200, 3'd3);
        #2;
        chk("ovf_e2_int", {31'd0, int_s}, 32'd1);
        cyc();
        chk("ovf_l2", {29'd0, nest_level}, 32'd2);
        ext_int = 4'b1010; pc = 16'h0090;
        #2;
        chk("full_no_int", {31'd0, int_s}, 32'd0);
        cyc();
        chk("overflow_set", {31'd0, overflow}, 32'd1);
        instruction = RETINT;
        #2;
        chk("full_ret_out", {16'd0, out}, 32'h0080);
        cyc();
        chk("full_ret_level", {29'd0, nest_level}, 32'd3);
        instruction = NOP; pc = 16'h00A0;
        expect_int(16'h0120, 3'd3);
        #2;
        chk("deferred_int", {31'd0, int_s}, 32'd1);
        cyc();
        chk("deferred_level", {29'd0, nest_level}, 32'd1);
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);
        ext_int = 4'b0000; instruction = RETINT;
        #2;
        chk("unwind1_out", {16'd0, out}, 32'h00A0);
        cyc();
        #2;
        chk("unwind2_out", {16'd0, out}, 32'h0070);
        cyc();
        chk("unwind_level", {29'd0, nest_level}, 32'd4);

        // Retint with an empty stack does nothing.
        #2;
        chk("empty_ret_out", {16'd0, out}, 32'd0);
        chk("empty_ret_reg", {28'd0, out_reg}, 32'd0);
        cyc();
        chk("empty_ret_level", {29'd0, nest_level}, 32'd4);

        instruction = NOP; cpu_update = 1'b0;
        repeat (3) cyc();
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
